// File: rtl/gpreg_pkg.sv
// rtl/gpreg_pkg.sv - shared op encodings and address-width helper for gpreg_file
package gpreg_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_LOAD = 2'b01,
        OP_INC  = 2'b10,
        OP_DEC  = 2'b11
    } gpreg_op_e;

    // A single-register file still needs a one-bit index port.
    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/gpreg_bus_driver.sv
// rtl/gpreg_bus_driver.sv - tri-state bus buffer with active-low enable
module gpreg_bus_driver #(
    parameter int WIDTH      = 8,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_bar_i,
    output wire  [WIDTH-1:0] bus_o
);

    // Zero-delay builds take the plain path; the delayed path is simulation-only.
    generate
        if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_nodly
            assign bus_o = en_bar_i ? {WIDTH{1'bz}} : data_i;
        end else begin : g_dly
            assign #(DELAY_RISE, DELAY_FALL) bus_o = en_bar_i ? {WIDTH{1'bz}} : data_i;
        end
    endgenerate

endmodule

// File: rtl/gpreg_file.sv
// rtl/gpreg_file.sv - register file with load/inc/dec, flags and three tri-state read buses
module gpreg_file
    import gpreg_pkg::*;
#(
    parameter int  WIDTH      = 8,
    parameter int  DEPTH      = 4,
    parameter int  DELAY_RISE = 0,
    parameter int  DELAY_FALL = 0,
    localparam int AW         = calc_aw(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_bar,
    input  logic [1:0]       OP,
    input  logic [AW-1:0]    WSEL,
    input  logic [WIDTH-1:0] DATA_in,
    input  logic [AW-1:0]    MAIN_SEL,
    input  logic [AW-1:0]    LHS_SEL,
    input  logic [AW-1:0]    RHS_SEL,
    input  logic             ASSERT_MAIN_bar,
    input  logic             ASSERT_LHS_bar,
    input  logic             ASSERT_RHS_bar,
    output wire  [WIDTH-1:0] MAIN_out,
    output wire  [WIDTH-1:0] LHS_out,
    output wire  [WIDTH-1:0] RHS_out,
    output logic             CARRY,
    output logic             ZERO,
    input  logic [AW-1:0]    DISPLAY_SEL,
    output logic [WIDTH-1:0] display_value
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             wsel_ok;
    logic [WIDTH-1:0] cur, res;

    logic [AW-1:0]    rsel  [4];
    logic [WIDTH-1:0] rdata [4];

    assign wsel_ok = int'(WSEL) < DEPTH;

    always_comb begin
        regs_d  = regs_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        cur     = '0;
        res     = '0;
        if (wsel_ok) begin
            cur = regs_q[WSEL];
            unique case (gpreg_op_e'(OP))
                OP_LOAD: begin
                    res          = DATA_in;
                    regs_d[WSEL] = res;
                    carry_d      = 1'b0;
                    zero_d       = (res == '0);
                end
                OP_INC: begin
                    res          = cur + 1'b1;
                    regs_d[WSEL] = res;
                    carry_d      = (cur == '1);
                    zero_d       = (res == '0);
                end
                OP_DEC: begin
                    res          = cur - 1'b1;
                    regs_d[WSEL] = res;
                    carry_d      = (cur == '0);
                    zero_d       = (res == '0);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign CARRY = carry_q;
    assign ZERO  = zero_q;

    // Out-of-range read indices return zero rather than an undefined word.
    assign rsel = '{MAIN_SEL, LHS_SEL, RHS_SEL, DISPLAY_SEL};

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            rdata[p] = '0;
            if (int'(rsel[p]) < DEPTH) rdata[p] = regs_q[rsel[p]];
        end
    end

    assign display_value = rdata[3];

    gpreg_bus_driver #(.WIDTH(WIDTH), .DELAY_RISE(DELAY_RISE), .DELAY_FALL(DELAY_FALL)) u_main_drv (
        .data_i   (rdata[0]),
        .en_bar_i (ASSERT_MAIN_bar),
        .bus_o    (MAIN_out)
    );

    gpreg_bus_driver #(.WIDTH(WIDTH), .DELAY_RISE(DELAY_RISE), .DELAY_FALL(DELAY_FALL)) u_lhs_drv (
        .data_i   (rdata[1]),
        .en_bar_i (ASSERT_LHS_bar),
        .bus_o    (LHS_out)
    );

    gpreg_bus_driver #(.WIDTH(WIDTH), .DELAY_RISE(DELAY_RISE), .DELAY_FALL(DELAY_FALL)) u_rhs_drv (
        .data_i   (rdata[2]),
        .en_bar_i (ASSERT_RHS_bar),
        .bus_o    (RHS_out)
    );

endmodule
